lcd_port_writer: RTL and testbench
==================================

// Module: lcd_port_writer
// PURPOSE
// - KCPSM3 output-port peripheral driving the Spartan-3 character LCD (HD44780, 4-bit bus, write-only).
// - The PicoBlaze OUTPUTs command/data bytes. The block queues them and serialises each byte as two nibbles with HD44780 timing.
// - Runs the power-on init sequence itself. Returns a status byte on a read port so firmware can poll instead of spinning.
// PARAMETERS
// CMD_PORT     8'h01   port_id for command bytes (RS=0)
// DATA_PORT    8'h02   port_id for character bytes (RS=1)
// STATUS_PORT  8'h03   port_id for status read
// T_PWR        750000  power-on wait, clk cycles (15 ms @ 50 MHz)
// T_INIT1      205000  wait after 1st init nibble (4.1 ms)
// T_INIT2      5000    wait after 2nd init nibble (100 us)
// T_SU         2       RS/data setup before E rises
// T_EH         12      E high width
// T_NIB        50      gap between high and low nibble (1 us)
// T_CMD        2000    wait after a byte (40 us); also after init nibbles 3 and 4
// T_CLR        82000   wait after command 8'h01 or 8'h02 (1.64 ms)
// PORTS
// clk           in   1  system clock
// reset_n       in   1  asynchronous active-low reset
// port_id       in   8  KCPSM3 port address
// write_strobe  in   1  KCPSM3 output strobe (1 cycle)
// out_port      in   8  KCPSM3 output data
// read_strobe   in   1  KCPSM3 input strobe (1 cycle)
// in_port       out  8  status byte to KCPSM3 (registered)
// lcd_d         out  4  LCD DB7..DB4
// lcd_e         out  1  LCD enable
// lcd_rs        out  1  0 = command, 1 = data
// lcd_rw        out  1  tied 0 (write only)
// busy          out  1  1 = init running, FIFO non-empty, or a byte in flight
// BEHAVIOUR
// Reset values (async, reset_n=0):
// - in_port=0, lcd_d=0, lcd_e=0, lcd_rs=0, lcd_rw=0, busy=1, FIFO empty, overflow=0, FSM=PWR_WAIT.
// - Reset mid-transfer aborts immediately, flushes the FIFO and reruns the full init sequence.
// Write side:
// - write_strobe && port_id==CMD_PORT pushes {0,out_port}. port_id==DATA_PORT pushes {1,out_port}. Other ports are ignored.
// - FIFO is 4 deep x 9 bits. A push while full is dropped and sets sticky overflow.
// - A push in the same cycle as a pop of a full FIFO is accepted; count is unchanged.
// Read side:
// - in_port registers every cycle. It is {5'b0, overflow, full, busy} when port_id==STATUS_PORT, else 8'h00.
// - read_strobe with port_id==STATUS_PORT clears overflow on the next edge. A set from a dropped push in the same cycle wins.
// FSM states:
// - PWR_WAIT -(T_PWR)-> INIT: nibbles 3,3,3,2 with RS=0. Each uses SETUP/E_HIGH timing, then waits T_INIT1, T_INIT2, T_CMD, T_CMD.
// - INIT -> IDLE. IDLE pops when the FIFO is non-empty, then loads rs and byte.
// - Per byte: SETUP_H(T_SU) -> EH_H(T_EH) -> GAP(T_NIB) -> SETUP_L(T_SU) -> EH_L(T_EH) -> WAIT -> IDLE.
// - WAIT lasts T_CLR if rs=0 and byte is 8'h01 or 8'h02, else T_CMD.
// Output timing:
// - lcd_d and lcd_rs are stable from SETUP entry until E falls, and held until the next SETUP.
// - lcd_e=1 only in EH_*. The high nibble goes first.
// - The delay counter is a single down-counter (18 bits minimum, sized from the largest parameter). It reloads on every state entry.
// - busy = (state!=IDLE) || !empty. It drops to 0 in the cycle IDLE is entered with the FIFO empty.
// STRUCTURE
// - lcd_defs.vh holds the port addresses, timing defaults and FSM state encodings. These are shared with the firmware constants header.
// - Sub-module lcd_cmd_fifo: 4x9 sync FIFO with push/pop/full/empty and simultaneous push+pop.
// - This module holds the port decode, status register, FSM and delay counter.
// TESTING (scaled timing: T_PWR=20, T_INIT1=10, T_INIT2=5, T_CMD=8, T_CLR=30)
// 1. Release reset. Check 4 E pulses with lcd_d=3,3,3,2, rs=0, gaps per params. busy goes 0 only after the last wait.
// 2. Write DATA_PORT 8'h41. Check E pulses with lcd_d=4 then 1, rs=1, E high exactly T_EH. Next E pulse no earlier than T_CMD.
// 3. Write CMD_PORT 8'h01. Check rs=0, nibbles 0 then 1, and the post-byte wait is T_CLR, not T_CMD.
// 4. Issue 6 back-to-back writes during init. The first 4 appear on the LCD in order. Status read gives 8'h07 (overflow, full, busy). The next status read gives 8'h03 or less, with bit2=0.
// 5. Write to port 8'h05 and read port 8'h04. No push, in_port=8'h00, LCD untouched.
// 6. Assert reset_n=0 while EH_L has lcd_e=1. lcd_e drops asynchronously, the FIFO is emptied, and init reruns from PWR_WAIT.

Source files
------------

// File: rtl/lcd_port_writer_pkg.sv
// Shared port addresses, timing defaults, FSM encoding and payload types for the
// KCPSM3 character-LCD port writer.
package lcd_port_writer_pkg;

  localparam logic [7:0] CMD_PORT    = 8'h01;
  localparam logic [7:0] DATA_PORT   = 8'h02;
  localparam logic [7:0] STATUS_PORT = 8'h03;

  localparam int unsigned T_PWR_DEF   = 750000;
  localparam int unsigned T_INIT1_DEF = 205000;
  localparam int unsigned T_INIT2_DEF = 5000;
  localparam int unsigned T_SU_DEF    = 2;
  localparam int unsigned T_EH_DEF    = 12;
  localparam int unsigned T_NIB_DEF   = 50;
  localparam int unsigned T_CMD_DEF   = 2000;
  localparam int unsigned T_CLR_DEF   = 82000;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W_MIN  = 18;

  typedef enum logic [3:0] {
    ST_PWR_WAIT   = 4'd0,
    ST_INIT_SETUP = 4'd1,
    ST_INIT_EH    = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_IDLE       = 4'd4,
    ST_SETUP_H    = 4'd5,
    ST_EH_H       = 4'd6,
    ST_GAP        = 4'd7,
    ST_SETUP_L    = 4'd8,
    ST_EH_L       = 4'd9,
    ST_WAIT       = 4'd10
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Power-on nibble sequence is 3,3,3,2 (switch to 4-bit mode on the last one).
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  // Clear display / return home need the long post-command wait.
  function automatic logic is_slow_cmd(input lcd_entry_t e);
    return !e.rs && ((e.data == 8'h01) || (e.data == 8'h02));
  endfunction

endpackage

// File: rtl/lcd_port_writer_cmd_fifo.sv
// 4-deep synchronous FIFO of LCD bytes; a push alongside a pop is accepted even when full.
module lcd_port_writer_cmd_fifo
  import lcd_port_writer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  lcd_entry_t wdata_i,
  input  logic       pop_i,
  output lcd_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  lcd_entry_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/lcd_port_writer.sv
// KCPSM3 output-port peripheral for an HD44780 LCD on a 4-bit write-only bus:
// port decode, status register, init/byte FSM and the shared delay counter.
module lcd_port_writer
  import lcd_port_writer_pkg::*;
#(
  parameter int unsigned T_PWR   = T_PWR_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF,
  parameter int unsigned T_SU    = T_SU_DEF,
  parameter int unsigned T_EH    = T_EH_DEF,
  parameter int unsigned T_NIB   = T_NIB_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_CLR   = T_CLR_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy
);

  localparam int unsigned T_MAX = max2(max2(max2(T_PWR, T_INIT1), max2(T_INIT2, T_CLR)),
                                       max2(max2(T_CMD, T_NIB), max2(T_SU, T_EH)));
  localparam int unsigned CNT_W = max2($clog2(T_MAX + 1), CNT_W_MIN);

  // A state loaded with dly(t) lasts exactly t cycles.
  function automatic logic [CNT_W-1:0] dly(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  lcd_entry_t       entry_q, entry_d;
  logic [3:0]       nib_q, nib_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       in_port_q, in_port_d;

  logic       tmo;
  logic       status_sel;
  logic       push_req;
  logic       pop_req;
  logic       fifo_full;
  logic       fifo_empty;
  lcd_entry_t fifo_wdata;
  lcd_entry_t fifo_rdata;

  assign status_sel = (port_id == STATUS_PORT);
  assign push_req   = write_strobe && ((port_id == CMD_PORT) || (port_id == DATA_PORT));
  assign fifo_wdata = '{rs: (port_id == DATA_PORT), data: out_port};

  lcd_port_writer_cmd_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_req),
    .wdata_i (fifo_wdata),
    .pop_i   (pop_req),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky overflow: a dropped push beats a same-cycle status-read clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full && !pop_req) begin
      ovf_d = 1'b1;
    end else if (read_strobe && status_sel) begin
      ovf_d = 1'b0;
    end
    in_port_d = status_sel ? {5'b0, ovf_q, fifo_full, busy_q} : 8'h00;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    entry_d    = entry_q;
    nib_d      = nib_q;
    rs_d       = rs_q;
    pop_req    = 1'b0;
    tmo        = (cnt_q == '0);

    unique case (state_q)
      ST_PWR_WAIT:   if (tmo) state_d = ST_INIT_SETUP;
      ST_INIT_SETUP: if (tmo) state_d = ST_INIT_EH;
      ST_INIT_EH:    if (tmo) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (tmo) begin
          if (init_idx_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT_SETUP;
          end
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_req = 1'b1;
          entry_d = fifo_rdata;
          state_d = ST_SETUP_H;
        end
      end
      ST_SETUP_H: if (tmo) state_d = ST_EH_H;
      ST_EH_H:    if (tmo) state_d = ST_GAP;
      ST_GAP:     if (tmo) state_d = ST_SETUP_L;
      ST_SETUP_L: if (tmo) state_d = ST_EH_L;
      ST_EH_L:    if (tmo) state_d = ST_WAIT;
      ST_WAIT:    if (tmo) state_d = ST_IDLE;
      default:    state_d = ST_PWR_WAIT;
    endcase

    // Counter reload and bus setup happen on state entry only.
    if (state_d != state_q) begin
      unique case (state_d)
        ST_PWR_WAIT: cnt_d = dly(T_PWR);
        ST_INIT_SETUP: begin
          nib_d = init_nibble(init_idx_d);
          rs_d  = 1'b0;
          cnt_d = dly(T_SU);
        end
        ST_SETUP_H: begin
          nib_d = entry_d.data[7:4];
          rs_d  = entry_d.rs;
          cnt_d = dly(T_SU);
        end
        ST_SETUP_L: begin
          nib_d = entry_q.data[3:0];
          cnt_d = dly(T_SU);
        end
        ST_INIT_EH, ST_EH_H, ST_EH_L: cnt_d = dly(T_EH);
        ST_GAP: cnt_d = dly(T_NIB);
        ST_INIT_WAIT: cnt_d = (init_idx_q == 2'd0) ? dly(T_INIT1) :
                              (init_idx_q == 2'd1) ? dly(T_INIT2) : dly(T_CMD);
        ST_WAIT: cnt_d = is_slow_cmd(entry_q) ? dly(T_CLR) : dly(T_CMD);
        default: cnt_d = '0;
      endcase
    end else if (!tmo) begin
      cnt_d = cnt_q - 1'b1;
    end

    e_d = (state_d == ST_INIT_EH) || (state_d == ST_EH_H) || (state_d == ST_EH_L);
    // No pop can coincide with state_d==IDLE, so a pending push alone keeps busy high.
    busy_d = (state_d != ST_IDLE) || !fifo_empty || push_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PWR_WAIT;
      cnt_q      <= dly(T_PWR);
      init_idx_q <= 2'd0;
      entry_q    <= '0;
      nib_q      <= 4'h0;
      rs_q       <= 1'b0;
      e_q        <= 1'b0;
      busy_q     <= 1'b1;
      ovf_q      <= 1'b0;
      in_port_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      entry_q    <= entry_d;
      nib_q      <= nib_d;
      rs_q       <= rs_d;
      e_q        <= e_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      in_port_q  <= in_port_d;
    end
  end

  assign in_port = in_port_q;
  assign lcd_d   = nib_q;
  assign lcd_e   = e_q;
  assign lcd_rs  = rs_q;
  assign lcd_rw  = 1'b0;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lcd_port_writer.sv
// Directed bench for lcd_port_writer with scaled timing; E pulses are logged by a
// negedge monitor and checked against hand-computed nibble/timing tables.
module tb_lcd_port_writer;

  localparam int T_PWR   = 20;
  localparam int T_INIT1 = 10;
  localparam int T_INIT2 = 5;
  localparam int T_SU    = 2;
  localparam int T_EH    = 12;
  localparam int T_NIB   = 50;
  localparam int T_CMD   = 8;
  localparam int T_CLR   = 30;

  localparam logic [7:0] P_CMD    = 8'h01;
  localparam logic [7:0] P_DATA   = 8'h02;
  localparam logic [7:0] P_STATUS = 8'h03;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic       read_strobe = 1'b0;
  logic [7:0] in_port;
  logic [3:0] lcd_d;
  logic       lcd_e, lcd_rs, lcd_rw, busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  lcd_port_writer #(
    .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SU(T_SU),
    .T_EH(T_EH), .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .out_port     (out_port),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .lcd_d        (lcd_d),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         rise;
    int         fall;
    logic [3:0] d;
    logic       rs;
    logic       stable;
  } pulse_t;

  pulse_t pq[$];
  pulse_t cur;
  logic   e_prev = 1'b0;

  // Log every E pulse: cycle of rise/fall, nibble, RS, and whether the bus held still.
  always @(negedge clk) begin
    if (lcd_e === 1'b1 && !e_prev) begin
      cur.rise = cyc; cur.d = lcd_d; cur.rs = lcd_rs; cur.stable = 1'b1;
    end else if (lcd_e === 1'b1) begin
      if (lcd_d !== cur.d || lcd_rs !== cur.rs) cur.stable = 1'b0;
    end
    if (lcd_e !== 1'b1 && e_prev) begin
      cur.fall = cyc;
      pq.push_back(cur);
    end
    e_prev = (lcd_e === 1'b1);
  end

  task automatic io_write(input logic [7:0] p, input logic [7:0] v);
    @(negedge clk);
    port_id = p; out_port = v; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0; port_id = 8'h00;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k = 0;
    while (pq.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    nvec++;
    if (pq.size() < n) begin
      nerr++;
      $display("FAIL %s: saw %0d E pulses, required %0d", tag, pq.size(), n);
    end
  endtask

  task automatic wait_busy_low(input int budget, input string tag, output int at);
    int k = 0;
    at = -1;
    while (k < budget) begin
      @(negedge clk); k++;
      if (busy === 1'b0) begin at = cyc; break; end
    end
    nvec++;
    if (at < 0) begin
      nerr++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    int rel, at;
    int gap [3] = '{T_INIT1 + T_SU, T_INIT2 + T_SU, T_CMD + T_SU};
    logic [3:0] exp_d [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({in_port, lcd_d, lcd_e, lcd_rs, lcd_rw, busy} !== {8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_vals: in_port=%h d=%h e=%b rs=%b rw=%b busy=%b, required 00 0 0 0 0 1",
               in_port, lcd_d, lcd_e, lcd_rs, lcd_rw, busy);
    end
    pq.delete();
    rel = cyc;
    reset_n = 1'b1;
    wait_pulses(4, 400, "init_pulses");
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL init_busy: busy=%b during last wait, required 1", busy); end
    for (int i = 0; i < 4 && i < pq.size(); i++) begin
      nvec++;
      if (pq[i].d !== exp_d[i] || pq[i].rs !== 1'b0 || pq[i].fall - pq[i].rise != T_EH || !pq[i].stable) begin
        nerr++;
        $display("FAIL init_nib%0d: d=%h rs=%b width=%0d stable=%b, required d=%h rs=0 width=%0d stable=1",
                 i, pq[i].d, pq[i].rs, pq[i].fall - pq[i].rise, pq[i].stable, exp_d[i], T_EH);
      end
    end
    if (pq.size() >= 4) begin
      nvec++;
      if (pq[0].rise - rel != T_PWR + T_SU) begin
        nerr++; $display("FAIL pwr_wait: first E after %0d cycles, required %0d", pq[0].rise - rel, T_PWR + T_SU);
      end
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (pq[i+1].rise - pq[i].fall != gap[i]) begin
          nerr++; $display("FAIL init_gap%0d: %0d cycles, required %0d", i, pq[i+1].rise - pq[i].fall, gap[i]);
        end
      end
      wait_busy_low(200, "init_busy_timeout", at);
      nvec++;
      if (at != pq[3].fall + T_CMD) begin
        nerr++; $display("FAIL init_done: busy low at %0d, required %0d", at, pq[3].fall + T_CMD);
      end
    end
  endtask

  task automatic test_data_byte();
    int at;
    pq.delete();
    io_write(P_DATA, 8'h41);
    wait_pulses(2, 300, "data_pulses");
    if (pq.size() >= 2) begin
      nvec++;
      if (pq[0].d !== 4'h4 || pq[1].d !== 4'h1 || pq[0].rs !== 1'b1 || pq[1].rs !== 1'b1) begin
        nerr++; $display("FAIL data_nibbles: %h/%h rs=%b%b, required 4/1 rs=11", pq[0].d, pq[1].d, pq[0].rs, pq[1].rs);
      end
      nvec++;
      if (pq[0].fall - pq[0].rise != T_EH || pq[1].fall - pq[1].rise != T_EH || !pq[0].stable || !pq[1].stable) begin
        nerr++; $display("FAIL data_eh: widths %0d/%0d stable=%b%b, required %0d stable=11",
                         pq[0].fall - pq[0].rise, pq[1].fall - pq[1].rise, pq[0].stable, pq[1].stable, T_EH);
      end
      nvec++;
      if (pq[1].rise - pq[0].fall != T_NIB + T_SU) begin
        nerr++; $display("FAIL data_gap: %0d cycles, required %0d", pq[1].rise - pq[0].fall, T_NIB + T_SU);
      end
      wait_busy_low(200, "data_busy_timeout", at);
      nvec++;
      if (at != pq[1].fall + T_CMD) begin
        nerr++; $display("FAIL data_wait: busy low at %0d, required %0d", at, pq[1].fall + T_CMD);
      end
    end
  endtask

  task automatic test_clear_cmd();
    int at;
    pq.delete();
    io_write(P_CMD, 8'h01);
    wait_pulses(2, 300, "clr_pulses");
    if (pq.size() >= 2) begin
      nvec++;
      if (pq[0].d !== 4'h0 || pq[1].d !== 4'h1 || pq[0].rs !== 1'b0 || pq[1].rs !== 1'b0) begin
        nerr++; $display("FAIL clr_nibbles: %h/%h rs=%b%b, required 0/1 rs=00", pq[0].d, pq[1].d, pq[0].rs, pq[1].rs);
      end
      wait_busy_low(300, "clr_busy_timeout", at);
      nvec++;
      if (at != pq[1].fall + T_CLR) begin
        nerr++; $display("FAIL clr_wait: busy low at %0d, required %0d", at, pq[1].fall + T_CLR);
      end
    end
  endtask

  task automatic test_overflow();
    int at;
    logic [3:0] exp_d [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h4, 4'h1, 4'h4, 4'h2, 4'h4, 4'h3, 4'h4, 4'h4};
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    pq.delete();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      port_id = P_DATA; out_port = 8'(8'h41 + i); write_strobe = 1'b1;
      @(negedge clk);
    end
    write_strobe = 1'b0; port_id = P_STATUS; read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    nvec++;
    if (in_port !== 8'h07) begin nerr++; $display("FAIL ovf_status: in_port=%h, required 07", in_port); end
    @(negedge clk);
    nvec++;
    if (in_port[2] !== 1'b0 || in_port > 8'h03) begin
      nerr++; $display("FAIL ovf_clear: in_port=%h, required <=03 with bit2=0", in_port);
    end
    port_id = 8'h00;
    wait_pulses(12, 2000, "ovf_pulses");
    for (int i = 0; i < 12 && i < pq.size(); i++) begin
      nvec++;
      if (pq[i].d !== exp_d[i] || pq[i].rs !== (i >= 4)) begin
        nerr++; $display("FAIL ovf_seq%0d: d=%h rs=%b, required d=%h rs=%b", i, pq[i].d, pq[i].rs, exp_d[i], i >= 4);
      end
    end
    wait_busy_low(300, "ovf_busy_timeout", at);
    repeat (5) @(negedge clk);
    nvec++;
    if (pq.size() != 12) begin nerr++; $display("FAIL ovf_dropped: %0d pulses, required 12", pq.size()); end
  endtask

  task automatic test_foreign_ports();
    int at;
    pq.delete();
    io_write(8'h05, 8'h41);
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL foreign_push: busy=%b after port 05 write, required 0", busy); end
    port_id = P_DATA; out_port = 8'h30; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0; port_id = 8'h04; read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    nvec++;
    if (in_port !== 8'h00) begin nerr++; $display("FAIL foreign_read: in_port=%h on port 04, required 00", in_port); end
    port_id = P_STATUS;
    @(negedge clk);
    nvec++;
    if (in_port !== 8'h01) begin nerr++; $display("FAIL busy_status: in_port=%h, required 01", in_port); end
    port_id = 8'h00;
    wait_busy_low(300, "foreign_busy_timeout", at);
    repeat (5) @(negedge clk);
    nvec++;
    if (pq.size() != 2 || pq[0].d !== 4'h3 || pq[1].d !== 4'h0) begin
      nerr++; $display("FAIL foreign_lcd: %0d pulses, required 2 carrying 3/0", pq.size());
    end
  endtask

  task automatic test_reset_mid_transfer();
    int k = 0;
    int rel, at;
    logic [3:0] exp_d [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    pq.delete();
    io_write(P_DATA, 8'h41);
    io_write(P_DATA, 8'h42);
    while (!(pq.size() >= 1 && lcd_e === 1'b1) && k < 400) begin
      @(negedge clk); k++;
    end
    nvec++;
    if (!(pq.size() >= 1 && lcd_e === 1'b1)) begin
      nerr++; $display("FAIL eh_l_reach: never saw low-nibble E, pulses=%0d", pq.size());
    end
    #1 reset_n = 1'b0;
    #1;
    nvec++;
    if (lcd_e !== 1'b0 || busy !== 1'b1 || lcd_d !== 4'h0) begin
      nerr++; $display("FAIL async_reset: e=%b busy=%b d=%h, required e=0 busy=1 d=0", lcd_e, busy, lcd_d);
    end
    repeat (2) @(negedge clk);
    pq.delete();
    rel = cyc;
    reset_n = 1'b1;
    wait_pulses(4, 400, "reinit_pulses");
    for (int i = 0; i < 4 && i < pq.size(); i++) begin
      nvec++;
      if (pq[i].d !== exp_d[i] || pq[i].rs !== 1'b0) begin
        nerr++; $display("FAIL reinit_nib%0d: d=%h rs=%b, required d=%h rs=0", i, pq[i].d, pq[i].rs, exp_d[i]);
      end
    end
    if (pq.size() >= 4) begin
      nvec++;
      if (pq[0].rise - rel != T_PWR + T_SU) begin
        nerr++; $display("FAIL reinit_pwr: first E after %0d cycles, required %0d", pq[0].rise - rel, T_PWR + T_SU);
      end
      wait_busy_low(300, "reinit_busy_timeout", at);
      nvec++;
      if (at != pq[3].fall + T_CMD) begin
        nerr++; $display("FAIL fifo_flush: busy low at %0d, required %0d", at, pq[3].fall + T_CMD);
      end
    end
    repeat (20) @(negedge clk);
    nvec++;
    if (pq.size() != 4 || busy !== 1'b0) begin
      nerr++; $display("FAIL reinit_quiet: %0d pulses busy=%b, required 4 pulses busy=0", pq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_data_byte();
    test_clear_cmd();
    test_overflow();
    test_foreign_ports();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
